// File: rtl/ahbl_splitter.sv
// rtl/ahbl_splitter.sv - 1:N AHB-Lite address-decoding splitter with steered data-phase response mux
// Optional internal ERROR default slave: define AHBL_SPLITTER_DEFAULT_ERR_EN
module ahbl_splitter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       src_hready,
    output logic                       src_hready_resp,
    output logic                       src_hresp,
    input  logic [W_ADDR-1:0]          src_haddr,
    input  logic                       src_hwrite,
    input  logic [1:0]                 src_htrans,
    input  logic [2:0]                 src_hsize,
    input  logic [2:0]                 src_hburst,
    input  logic [3:0]                 src_hprot,
    input  logic                       src_hmastlock,
    input  logic [W_DATA-1:0]          src_hwdata,
    output logic [W_DATA-1:0]          src_hrdata,
    output logic [N_PORTS-1:0]         dst_hready,
    input  logic [N_PORTS-1:0]         dst_hready_resp,
    input  logic [N_PORTS-1:0]         dst_hresp,
    output logic [N_PORTS*W_ADDR-1:0]  dst_haddr,
    output logic [N_PORTS-1:0]         dst_hwrite,
    output logic [N_PORTS*2-1:0]       dst_htrans,
    output logic [N_PORTS*3-1:0]       dst_hsize,
    output logic [N_PORTS*3-1:0]       dst_hburst,
    output logic [N_PORTS*4-1:0]       dst_hprot,
    output logic [N_PORTS-1:0]         dst_hmastlock,
    output logic [N_PORTS*W_DATA-1:0]  dst_hwdata,
    input  logic [N_PORTS*W_DATA-1:0]  dst_hrdata
);

    logic [N_PORTS-1:0] match_raw;
    logic [N_PORTS-1:0] sel_a;
    logic [N_PORTS-1:0] dsel_q;
    logic [N_PORTS-1:0] dsel_d;

    always_comb begin
        match_raw = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            match_raw[i] = ((src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR]);
        end
    end

    // Scan high to low so the lowest matching index is the last one written.
    always_comb begin
        sel_a = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (match_raw[i]) begin
                sel_a    = '0;
                sel_a[i] = 1'b1;
            end
        end
        if (!src_htrans[1]) begin
            sel_a = '0;
        end
    end

    always_comb begin
        dst_htrans = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            dst_htrans[2*i +: 2] = sel_a[i] ? src_htrans : 2'b00;
        end
    end

    assign dst_hready    = {N_PORTS{src_hready}};
    assign dst_haddr     = {N_PORTS{src_haddr}};
    assign dst_hwrite    = {N_PORTS{src_hwrite}};
    assign dst_hsize     = {N_PORTS{src_hsize}};
    assign dst_hburst    = {N_PORTS{src_hburst}};
    assign dst_hprot     = {N_PORTS{src_hprot}};
    assign dst_hmastlock = {N_PORTS{src_hmastlock}};
    assign dst_hwdata    = {N_PORTS{src_hwdata}};

    assign dsel_d = src_hready ? sel_a : dsel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsel_q <= '0;
        end else begin
            dsel_q <= dsel_d;
        end
    end

`ifdef AHBL_SPLITTER_DEFAULT_ERR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_t;

    err_state_t state_q;
    err_state_t state_d;
    logic       derr_q;
    logic       derr_d;
    logic       unmapped_a;
    logic       err_active;

    assign unmapped_a = src_htrans[1] & ~|match_raw;
    assign derr_d     = src_hready ? unmapped_a : derr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (src_hready && unmapped_a) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: if (src_hready) state_d = unmapped_a ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            derr_q  <= derr_d;
        end
    end

    assign err_active = derr_q & (state_q != ST_IDLE);
`endif

    // With no slave owning the data phase the response is a zero-wait OKAY unless the default slave is erroring.
    always_comb begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b0;
        src_hrdata      = '0;
        if (|dsel_q) begin
            src_hready_resp = |(dsel_q & dst_hready_resp);
            src_hresp       = |(dsel_q & dst_hresp);
            for (int i = 0; i < N_PORTS; i++) begin
                if (dsel_q[i]) begin
                    src_hrdata = dst_hrdata[i*W_DATA +: W_DATA];
                end
            end
        end
`ifdef AHBL_SPLITTER_DEFAULT_ERR_EN
        else if (err_active) begin
            src_hready_resp = (state_q != ST_ERR1);
            src_hresp       = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_ahbl_splitter.sv
// tb/tb_ahbl_splitter.sv - randomized transfer-level check of ahbl_splitter against a decode/response model
module tb_ahbl_splitter;
    localparam int N  = 3;
    localparam int WA = 32;
    localparam int WD = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              src_hready;
    logic              src_hready_resp;
    logic              src_hresp;
    logic [WA-1:0]     src_haddr;
    logic              src_hwrite;
    logic [1:0]        src_htrans;
    logic [2:0]        src_hsize;
    logic [2:0]        src_hburst;
    logic [3:0]        src_hprot;
    logic              src_hmastlock;
    logic [WD-1:0]     src_hwdata;
    logic [WD-1:0]     src_hrdata;
    logic [N-1:0]      dst_hready;
    logic [N-1:0]      dst_hready_resp;
    logic [N-1:0]      dst_hresp;
    logic [N*WA-1:0]   dst_haddr;
    logic [N-1:0]      dst_hwrite;
    logic [N*2-1:0]    dst_htrans;
    logic [N*3-1:0]    dst_hsize;
    logic [N*3-1:0]    dst_hburst;
    logic [N*4-1:0]    dst_hprot;
    logic [N-1:0]      dst_hmastlock;
    logic [N*WD-1:0]   dst_hwdata;
    logic [N*WD-1:0]   dst_hrdata;

    // Port 2 overlaps port 1 on 0x2xxx_xxxx so the lowest-index-wins rule is exercised.
    ahbl_splitter #(
        .N_PORTS  (N),
        .W_ADDR   (WA),
        .W_DATA   (WD),
        .ADDR_MAP ({32'h2000_0000, 32'h2000_0000, 32'h0000_0000}),
        .ADDR_MASK({32'hE000_0000, 32'hF000_0000, 32'hF000_0000})
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_hready     (src_hready),
        .src_hready_resp(src_hready_resp),
        .src_hresp      (src_hresp),
        .src_haddr      (src_haddr),
        .src_hwrite     (src_hwrite),
        .src_htrans     (src_htrans),
        .src_hsize      (src_hsize),
        .src_hburst     (src_hburst),
        .src_hprot      (src_hprot),
        .src_hmastlock  (src_hmastlock),
        .src_hwdata     (src_hwdata),
        .src_hrdata     (src_hrdata),
        .dst_hready     (dst_hready),
        .dst_hready_resp(dst_hready_resp),
        .dst_hresp      (dst_hresp),
        .dst_haddr      (dst_haddr),
        .dst_hwrite     (dst_hwrite),
        .dst_htrans     (dst_htrans),
        .dst_hsize      (dst_hsize),
        .dst_hburst     (dst_hburst),
        .dst_hprot      (dst_hprot),
        .dst_hmastlock  (dst_hmastlock),
        .dst_hwdata     (dst_hwdata),
        .dst_hrdata     (dst_hrdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model state: address phase on the bus and the transfer owning the data phase.
    // dp_kind: -1 none, 0..N-1 slave port, N unmapped.
    logic [1:0]  ap_trans;
    logic [31:0] ap_addr;
    logic        ap_write;
    logic [2:0]  ap_size;
    logic [2:0]  ap_burst;
    logic [3:0]  ap_prot;
    logic        ap_lock;
    int          dp_kind;
    int          dp_waits;
    int          dp_errph;
    logic [31:0] dp_rdata;
    logic [31:0] dp_wdata;
    logic        m_ready;
    logic        m_resp;
    logic [31:0] m_rdata;

    function automatic int decode(input logic [31:0] a);
        case (a[31:28])
            4'h0:    return 0;
            4'h2:    return 1;
            4'h3:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [5:0] exp_htrans();
        logic [5:0] v;
        int p;
        v = '0;
        p = decode(ap_addr);
        if (ap_trans[1] && p >= 0) v[2*p +: 2] = ap_trans;
        return v;
    endfunction

    task automatic new_ap();
        int r;
        logic [3:0] regions [5];
        regions = '{4'h0, 4'h2, 4'h3, 4'h8, 4'h1};
        r = $urandom_range(0, 9);
        ap_trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        ap_addr  = {regions[$urandom_range(0, 4)], 28'($urandom)};
        ap_write = 1'($urandom);
        ap_size  = 3'($urandom);
        ap_burst = 3'($urandom);
        ap_prot  = 4'($urandom);
        ap_lock  = 1'($urandom);
    endtask

    task automatic model_outputs();
        m_ready = 1'b1;
        m_resp  = 1'b0;
        m_rdata = '0;
        if (dp_kind >= 0 && dp_kind < N) begin
            m_ready = (dp_waits == 0);
            m_rdata = dp_rdata;
        end
`ifdef AHBL_SPLITTER_DEFAULT_ERR_EN
        else if (dp_kind == N) begin
            m_resp  = 1'b1;
            m_ready = (dp_errph == 2);
        end
`endif
    endtask

    // Effect of the clock edge just taken: accept the address phase or age the current data phase.
    task automatic advance();
        if (m_ready) begin
            if (ap_trans[1]) dp_kind = (decode(ap_addr) < 0) ? N : decode(ap_addr);
            else             dp_kind = -1;
            dp_waits = $urandom_range(0, 2);
            dp_errph = 1;
            dp_rdata = $urandom;
            dp_wdata = $urandom;
            new_ap();
        end else begin
            if (dp_kind >= 0 && dp_kind < N) dp_waits--;
            else if (dp_kind == N)           dp_errph = 2;
        end
    endtask

    task automatic drive();
        model_outputs();
        src_hready    = m_ready;
        src_htrans    = ap_trans;
        src_haddr     = ap_addr;
        src_hwrite    = ap_write;
        src_hsize     = ap_size;
        src_hburst    = ap_burst;
        src_hprot     = ap_prot;
        src_hmastlock = ap_lock;
        src_hwdata    = dp_wdata;
        for (int p = 0; p < N; p++) begin
            if (dp_kind == p) begin
                dst_hready_resp[p]      = (dp_waits == 0);
                dst_hresp[p]            = 1'b0;
                dst_hrdata[p*WD +: WD]  = dp_rdata;
            end else begin
                dst_hready_resp[p]      = 1'($urandom);
                dst_hresp[p]            = 1'b1;
                dst_hrdata[p*WD +: WD]  = $urandom;
            end
        end
    endtask

    task automatic check_cycle();
        @(negedge clk);
        check("hready_resp", src_hready_resp, m_ready);
        check("hresp", src_hresp, m_resp);
        check("hrdata", src_hrdata, m_rdata);
        check("dst_htrans", dst_htrans, exp_htrans());
        check("dst_haddr", dst_haddr, {N{ap_addr}});
        check("dst_hwdata", dst_hwdata, {N{dp_wdata}});
        check("dst_hready", dst_hready, {N{m_ready}});
        check("dst_ctrl", {dst_hwrite, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock},
              {{N{ap_write}}, {N{ap_size}}, {N{ap_burst}}, {N{ap_prot}}, {N{ap_lock}}});
    endtask

    initial begin
        int n_resets;
        bit reset_armed;
        n_resets    = 0;
        reset_armed = 1'b0;
        rst_n       = 1'b0;
        dp_kind     = -1;
        dp_waits    = 0;
        dp_errph    = 1;
        dp_rdata    = '0;
        dp_wdata    = '0;
        ap_trans    = 2'b00;
        ap_addr     = '0;
        ap_write    = 1'b0;
        ap_size     = '0;
        ap_burst    = '0;
        ap_prot     = '0;
        ap_lock     = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        check_cycle();

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        new_ap();
        drive();
        check_cycle();

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            advance();
            if (c % 400 == 399) reset_armed = 1'b1;
            if (reset_armed && dp_kind >= 0 && dp_kind < N && dp_waits > 0) begin
                // Reset lands in a slave wait state; the response must drop to OKAY at once.
                reset_armed = 1'b0;
                n_resets++;
                rst_n    = 1'b0;
                dp_kind  = -1;
                ap_trans = 2'b00;
                drive();
                check_cycle();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                new_ap();
                drive();
            end else begin
                drive();
            end
            check_cycle();
        end
        check("mid_transfer_resets", (n_resets > 0), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ahbl_splitter.md
Name: ahbl_splitter

Overview:
- 1:N AHB-Lite splitter. It sits directly downstream of the strict-priority N:1 arbiter and consumes its master-side output.
- Address-decodes each transfer onto one of N slave ports and steers data-phase responses back.
- Contains an internal default slave that returns the two-cycle AHB ERROR response for unmapped addresses.
- Typical use: arbiter output -> ahbl_splitter -> SRAM, APB bridge, peripherals.

Parameters:
N_PORTS, 2, number of slave ports (>=1)
W_ADDR, 32, address width
W_DATA, 32, data width
ADDR_MAP, {N_PORTS*W_ADDR{1'b0}}, concatenated per-port base addresses, port 0 in LSBs
ADDR_MASK, {N_PORTS*W_ADDR{1'b0}}, concatenated per-port decode masks; port i matches when (haddr & mask_i) == map_i

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
src_hready  input  1  system HREADY seen by upstream (arbiter dst_hready)
src_hready_resp  output  1  HREADYOUT to upstream
src_hresp  output  1  HRESP to upstream
src_haddr  input  W_ADDR  address
src_hwrite  input  1  write flag
src_htrans  input  2  transfer type
src_hsize  input  3  size
src_hburst  input  3  burst
src_hprot  input  4  protection
src_hmastlock  input  1  lock
src_hwdata  input  W_DATA  write data
src_hrdata  output  W_DATA  read data
dst_hready  output  N_PORTS  HREADY to each slave
dst_hready_resp  input  N_PORTS  HREADYOUT from each slave
dst_hresp  input  N_PORTS  HRESP from each slave
dst_haddr  output  N_PORTS*W_ADDR  broadcast address
dst_hwrite  output  N_PORTS  broadcast
dst_htrans  output  N_PORTS*2  gated per port
dst_hsize  output  N_PORTS*3  broadcast
dst_hburst  output  N_PORTS*3  broadcast
dst_hprot  output  N_PORTS*4  broadcast
dst_hmastlock  output  N_PORTS  broadcast
dst_hwdata  output  N_PORTS*W_DATA  broadcast
dst_hrdata  input  N_PORTS*W_DATA  read data from each slave

Behaviour:
- Decode (combinational): match[i] = ((src_haddr & mask_i) == map_i). On overlapping regions the lowest index wins, giving a one-hot sel_a. sel_a is zeroed when src_htrans[1] == 0.
- Address phase:
  - dst_htrans of port i = src_htrans if sel_a[i], else 2'b00 (IDLE).
  - All other address signals, dst_hwdata and dst_hready are replicated to every port unchanged. Zero added latency.
- Data-phase registers update only when src_hready = 1:
  - sel_d <= sel_a
  - err_d <= src_htrans[1] & ~|match_raw
  - Reset values: sel_d = 0, err_d = 0.
- Response mux:
  - When sel_d is non-zero: src_hready_resp, src_hresp and src_hrdata come from the port selected by sel_d.
  - When sel_d = 0 and no error is pending: src_hready_resp = 1, src_hresp = 0, src_hrdata = 0. This covers IDLE/BUSY transfers: zero-wait OKAY.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 when an unmapped active transfer is accepted (src_hready = 1).
  - ERR1: hready_resp = 0, hresp = 1. Always -> ERR2 next cycle.
  - ERR2: hready_resp = 1, hresp = 1. -> ERR1 if another unmapped transfer is accepted this cycle, else -> IDLE.
- Back-to-back: the address phase accepted in ERR2, or in the last ready cycle of a slave data phase, is decoded normally.
- Slave wait states: while src_hready = 0, sel_d, err_d and the FSM hold.
- Reset mid-transfer: everything returns to the reset state immediately. Outputs become src_hready_resp = 1, src_hresp = 0, src_hrdata = 0.
- N_PORTS = 1 is legal. Mask all-zero with base zero maps the full address space to that port.

Optional Feature:
- Macro: AHBL_SPLITTER_DEFAULT_ERR_EN.
- Defined: unmapped active transfers receive the two-cycle ERROR response via the FSM above.
- Undefined: the FSM and err_d are removed. Unmapped transfers complete in one cycle with src_hready_resp = 1, src_hresp = 0, src_hrdata = 0; writes are silently dropped.

Test Plan:
- N_PORTS=2, map0=0x0000_0000/mask 0xF000_0000, map1=0x2000_0000/mask 0xF000_0000. NONSEQ read 0x2000_0010, slave1 returns 0xCAFEF00D with one wait state -> dst_htrans[1]=NONSEQ, dst_htrans[0]=IDLE; src_hready_resp low one cycle, then src_hrdata=0xCAFEF00D.
- Back-to-back: write 0x0000_0004 then read 0x2000_0000 pipelined -> slave0 sees hwdata in the cycle slave1 sees its address; responses return in order with no bubble.
- Unmapped read 0x8000_0000 with macro defined -> cycle1: ready_resp=0, hresp=1; cycle2: ready_resp=1, hresp=1; no dst_htrans active.
- Same stimulus without the macro -> single-cycle OKAY, src_hrdata=0.
- IDLE and BUSY transfers to mapped addresses -> all dst_htrans IDLE, OKAY zero-wait.
- Assert rst_n during a slave wait state -> src_hready_resp=1, src_hresp=0 immediately; next transfer after release decodes correctly.
